uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler_pkg.sv | 20 ++
 rtl/uart_tx_byte.sv | 61 ++++++
 rtl/uart_tx_scheduler.sv | 115 +++++++++++
 tb/tb_uart_tx_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// rtl/uart_tx_scheduler_pkg.sv - shared constants and types for the UART packet scheduler
package uart_tx_scheduler_pkg;

  localparam int UART_LEN    = 8;
  localparam int FULL_PERIOD = 867;
  localparam int LEN_W       = 4;

  localparam logic [3:0] DBG_OP_NOP   = 4'h0;
  localparam logic [3:0] DBG_OP_STATE = 4'h1;
  localparam logic [3:0] DBG_OP_GRANT = 4'h2;
  localparam logic [3:0] DBG_OP_BYTE  = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } sched_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with registered line output
module uart_tx_byte #(
  parameter int FULL_PERIOD = uart_tx_scheduler_pkg::FULL_PERIOD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_start,
  input  logic [7:0] byte_in,
  output logic       byte_done,
  output logic       tx
);
  import uart_tx_scheduler_pkg::*;

  localparam int CNT_W = (FULL_PERIOD > 0) ? $clog2(FULL_PERIOD + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FULL_PERIOD);
  localparam logic [3:0]       LAST_BIT = 4'(UART_LEN + 1);

  logic                  r_active;
  logic [3:0]            r_bit;
  logic [CNT_W-1:0]      r_cnt;
  logic [UART_LEN+1:0]   r_shift;
  logic                  r_tx;
  logic                  w_bit_end;

  assign w_bit_end = r_active && (r_cnt == LAST_CNT);
  assign byte_done = w_bit_end && (r_bit == LAST_BIT);
  assign tx        = r_tx;

  // r_shift holds the remaining frame; bit 0 is the one currently on the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_bit    <= '0;
      r_cnt    <= '0;
      r_shift  <= '1;
      r_tx     <= 1'b1;
    end else if (!r_active) begin
      if (byte_start) begin
        r_active <= 1'b1;
        r_shift  <= {1'b1, byte_in, 1'b0};
        r_tx     <= 1'b0;
        r_cnt    <= '0;
        r_bit    <= '0;
      end
    end else if (w_bit_end) begin
      r_cnt <= '0;
      if (r_bit == LAST_BIT) begin
        r_active <= 1'b0;
        r_bit    <= '0;
        r_tx     <= 1'b1;
      end else begin
        r_bit   <= r_bit + 4'd1;
        r_shift <= {1'b1, r_shift[UART_LEN+1:1]};
        r_tx    <= r_shift[1];
      end
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin packet arbiter feeding a UART byte serializer
module uart_tx_scheduler #(
  parameter int NUM_REQ     = 3,
  parameter int MAX_BYTES   = 10,
  parameter int FULL_PERIOD = uart_tx_scheduler_pkg::FULL_PERIOD
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*MAX_BYTES*8-1:0] req_data,
  input  logic [NUM_REQ*4-1:0]           req_len,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy,
  output logic                           uart_tx
);
  import uart_tx_scheduler_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BUF_W = MAX_BYTES * UART_LEN;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

  sched_state_t     r_state, w_next;
  logic [IDX_W-1:0] r_ptr, r_win, w_win;
  logic [BUF_W-1:0] r_buf, w_data;
  logic [LEN_W-1:0] r_len, r_idx, w_len;
  logic             w_any, w_last, w_byte_start, w_byte_done;

  // Scan from the highest offset down so the nearest requester after r_ptr wins
  always_comb begin : arbiter
    int cand;
    cand   = 0;
    w_win  = r_ptr;
    w_data = '0;
    w_len  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = int'(r_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req[IDX_W'(cand)]) w_win = IDX_W'(cand);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IDX_W'(i)) begin
        w_data = req_data[i*BUF_W +: BUF_W];
        w_len  = req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  assign w_any        = |req;
  assign w_last       = (r_idx + LEN_W'(1)) == r_len;
  assign w_byte_start = (r_state == ST_SEND) && (r_len != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_any) w_next = ST_SEND;
      ST_SEND: w_next = (r_len == '0) ? ST_DONE : ST_WAIT;
      ST_WAIT: if (w_byte_done) w_next = w_last ? ST_DONE : ST_SEND;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // The buffer shifts down one byte per sent byte, so byte[index] is always the low byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= IDX_W'(NUM_REQ - 1);
      r_win <= '0;
      r_buf <= '0;
      r_len <= '0;
      r_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_any) begin
          r_win <= w_win;
          r_buf <= w_data;
          r_len <= (w_len > MAX_LEN) ? MAX_LEN : w_len;
          r_idx <= '0;
        end
        ST_WAIT: if (w_byte_done && !w_last) begin
          r_idx <= r_idx + LEN_W'(1);
          r_buf <= r_buf >> UART_LEN;
        end
        ST_DONE: r_ptr <= r_win;
        default: ;
      endcase
    end
  end

  always_comb begin
    grant = '0;
    done  = '0;
    if (r_state == ST_SEND || r_state == ST_WAIT) grant[r_win] = 1'b1;
    if (r_state == ST_DONE)                       done[r_win]  = 1'b1;
  end

  assign busy = (r_state != ST_IDLE);

  uart_tx_byte #(
    .FULL_PERIOD (FULL_PERIOD)
  ) u_byte (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_start (w_byte_start),
    .byte_in    (r_buf[UART_LEN-1:0]),
    .byte_done  (w_byte_done),
    .tx         (uart_tx)
  );

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

  localparam int NR    = 3;
  localparam int MB    = 10;
  localparam int FP    = 7;
  localparam int BIT   = FP + 1;
  localparam int FRAME = 10 * BIT;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NR-1:0]       req;
  logic [NR*MB*8-1:0]  req_data;
  logic [NR*4-1:0]     req_len;
  logic [NR-1:0]       grant, done;
  logic                busy, uart_tx;

  uart_tx_scheduler #(.NUM_REQ(NR), .MAX_BYTES(MB), .FULL_PERIOD(FP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .req_len  (req_len),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .uart_tx  (uart_tx)
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_data [NR][MB];
  int         m_len  [NR];
  int         m_ptr;

  logic       line_q[$];
  int         gnt_q[$], gnt_t[$], done_q[$], done_t[$];
  int         viol;
  int         last_g;
  logic [NR-1:0] prev_grant;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int eff(input int l);
    return (l > MB) ? MB : l;
  endfunction

  task automatic clear_log();
    line_q.delete(); gnt_q.delete(); gnt_t.delete(); done_q.delete(); done_t.delete();
    viol = 0; prev_grant = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    line_q.push_back(uart_tx);
    if (!$onehot0(grant)) viol++;
    if (grant !== '0 && prev_grant === '0) begin
      gnt_q.push_back(idx_of(grant));
      gnt_t.push_back(line_q.size() - 1);
    end
    if (done !== '0) begin
      if (!$onehot(done) || grant !== '0 || idx_of(done) != last_g) viol++;
      done_q.push_back(idx_of(done));
      done_t.push_back(line_q.size() - 1);
    end
    if (grant !== '0) last_g = idx_of(grant);
    prev_grant = grant;
  endtask

  task automatic apply_model();
    for (int r = 0; r < NR; r++) begin
      for (int j = 0; j < MB; j++) req_data[(r*MB+j)*8 +: 8] = m_data[r][j];
      req_len[r*4 +: 4] = 4'(m_len[r]);
    end
  endtask

  task automatic rand_data();
    for (int r = 0; r < NR; r++)
      for (int j = 0; j < MB; j++) m_data[r][j] = 8'($urandom);
  endtask

  task automatic build_order(input logic [NR-1:0] mask, input logic [NR-1:0] sticky,
                             input int n, output int order[$]);
    logic [NR-1:0] pend;
    pend = mask;
    order.delete();
    while (pend != '0 && order.size() < n) begin
      int w;
      w = -1;
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_ptr + k) % NR;
        if (w < 0 && pend[c]) w = c;
      end
      order.push_back(w);
      if (!sticky[w]) pend[w] = 1'b0;
      m_ptr = w;
    end
  endtask

  task automatic run(input string tag, input logic [NR-1:0] sticky, input int stop_after);
    int c;
    bit to;
    c = 0; to = 0;
    forever begin
      tick(); c++;
      if (done !== '0) begin
        req = req & ~(done & ~sticky);
        if (done_q.size() >= stop_after) req = '0;
      end
      if (req == '0 && busy === 1'b0) break;
      if (c >= 5000) begin to = 1; break; end
    end
    check({tag, "_timeout"}, 64'(to), 64'd0);
  endtask

  task automatic decode(output logic [7:0] got[$], output int st[$], output int bad);
    int t;
    t = 0; bad = 0;
    got.delete(); st.delete();
    while (t < line_q.size()) begin
      if (line_q[t] === 1'b0) begin
        logic [7:0] b;
        b = '0;
        if (t + FRAME > line_q.size()) begin bad++; break; end
        for (int k = 0; k < 10; k++) begin
          logic v;
          v = line_q[t + k*BIT];
          for (int m = 1; m < BIT; m++) if (line_q[t + k*BIT + m] !== v) bad++;
          if (k == 9 && v !== 1'b1) bad++;
          if (k >= 1 && k <= 8) b[k-1] = v;
        end
        got.push_back(b); st.push_back(t); t += FRAME;
      end else begin
        if (line_q[t] !== 1'b1) bad++;
        t++;
      end
    end
  endtask

  task automatic verify(input string tag, input int order[$]);
    logic [7:0] got[$];
    int st[$];
    int bad, f, ordbad, bytebad, gapbad, tbad;
    decode(got, st, bad);
    f = 0; ordbad = 0; bytebad = 0; gapbad = 0; tbad = 0;
    for (int p = 0; p < order.size(); p++) begin
      int r, l;
      r = order[p]; l = eff(m_len[r]);
      if (p < gnt_q.size() && gnt_q[p] != r) ordbad++;
      if (p < done_q.size() && done_q[p] != r) ordbad++;
      if (p + 1 < gnt_t.size() && p < done_t.size() && done_t[p] >= gnt_t[p+1]) ordbad++;
      for (int j = 0; j < l; j++) begin
        if (f + j < got.size()) begin
          if (got[f+j] !== m_data[r][j]) bytebad++;
          if (j > 0 && st[f+j] - st[f+j-1] != FRAME + 1) gapbad++;
        end else bytebad++;
      end
      if (l > 0 && f < st.size() && p < gnt_t.size() && st[f] != gnt_t[p] + 1) tbad++;
      if (l > 0 && f + l - 1 < st.size() && p < done_t.size() && done_t[p] != st[f+l-1] + FRAME) tbad++;
      f += l;
    end
    check({tag, "_frames"},  64'(bad), 64'd0);
    check({tag, "_ngrant"},  64'(gnt_q.size()), 64'(order.size()));
    check({tag, "_ndone"},   64'(done_q.size()), 64'(order.size()));
    check({tag, "_order"},   64'(ordbad), 64'd0);
    check({tag, "_nbytes"},  64'(got.size()), 64'(f));
    check({tag, "_bytes"},   64'(bytebad), 64'd0);
    check({tag, "_gap"},     64'(gapbad), 64'd0);
    check({tag, "_timing"},  64'(tbad), 64'd0);
    check({tag, "_onehot"},  64'(viol), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    m_ptr = NR - 1;
    tick();
  endtask

  initial begin
    int order[$];
    int zeros;
    rst_n = 1'b0; req = '0; req_data = '0; req_len = '0;
    m_ptr = NR - 1; last_g = -1;
    clear_log();

    // reset state
    repeat (3) tick();
    check("rst_tx",    64'(uart_tx), 64'd1);
    check("rst_grant", 64'(grant),   64'd0);
    check("rst_done",  64'(done),    64'd0);
    check("rst_busy",  64'(busy),    64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", 64'(busy),    64'd0);
    check("idle_tx",   64'(uart_tx), 64'd1);

    // single requester, two bytes A55A
    rand_data();
    for (int r = 0; r < NR; r++) m_len[r] = 1;
    m_data[1][0] = 8'h5A; m_data[1][1] = 8'hA5; m_len[1] = 2;
    apply_model();
    clear_log();
    build_order(3'b010, 3'b000, 99, order);
    req = 3'b010;
    run("s1", 3'b000, 99);
    check("s1_grant_lat", 64'(gnt_t.size() > 0 ? gnt_t[0] : -1), 64'd0);
    verify("s1", order);

    // all three right after reset
    do_reset();
    rand_data();
    for (int r = 0; r < NR; r++) m_len[r] = 1;
    apply_model();
    clear_log();
    build_order(3'b111, 3'b000, 99, order);
    req = 3'b111;
    run("s2", 3'b000, 99);
    verify("s2", order);

    // two held requesters alternate
    rand_data();
    apply_model();
    clear_log();
    build_order(3'b101, 3'b101, 4, order);
    req = 3'b101;
    run("s3", 3'b101, 4);
    verify("s3", order);

    // zero length, then over-long length
    m_len[0] = 0;
    apply_model();
    clear_log();
    build_order(3'b001, 3'b000, 99, order);
    req = 3'b001;
    run("s4a", 3'b000, 99);
    zeros = 0;
    foreach (line_q[i]) if (line_q[i] !== 1'b1) zeros++;
    check("s4a_line_high", 64'(zeros), 64'd0);
    check("s4a_done_tick", 64'(done_t.size() > 0 ? done_t[0] : -1), 64'd1);
    verify("s4a", order);

    rand_data();
    m_len[0] = 15;
    apply_model();
    clear_log();
    build_order(3'b001, 3'b000, 99, order);
    req = 3'b001;
    run("s4b", 3'b000, 99);
    verify("s4b", order);

    // inputs change after grant
    rand_data();
    m_len[2] = 3;
    apply_model();
    clear_log();
    build_order(3'b100, 3'b000, 99, order);
    req = 3'b100;
    tick();
    req_data = ~req_data;
    req_len  = ~req_len;
    run("s5", 3'b000, 99);
    verify("s5", order);

    // random masks, lengths and payloads
    for (int n = 0; n < 4; n++) begin
      logic [NR-1:0] mask;
      mask = NR'($urandom_range(1, 7));
      rand_data();
      for (int r = 0; r < NR; r++) m_len[r] = $urandom_range(0, 12);
      apply_model();
      clear_log();
      build_order(mask, 3'b000, 99, order);
      req = mask;
      run($sformatf("s6_%0d", n), 3'b000, 99);
      verify($sformatf("s6_%0d", n), order);
    end

    // asynchronous reset in the middle of a data bit of byte 1
    rand_data();
    m_len[1] = 3;
    m_data[1][1] = 8'h00;
    apply_model();
    clear_log();
    req = 3'b010;
    while (line_q.size() < 117) tick();
    check("s7_pre_line", 64'(line_q[116]), 64'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check("s7_rst_tx",    64'(uart_tx), 64'd1);
    check("s7_rst_grant", 64'(grant),   64'd0);
    check("s7_rst_busy",  64'(busy),    64'd0);
    check("s7_rst_done",  64'(done),    64'd0);
    repeat (2) tick();
    clear_log();
    m_ptr = NR - 1;
    rst_n = 1'b1;
    build_order(3'b010, 3'b000, 99, order);
    run("s7", 3'b000, 99);
    verify("s7", order);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
